// File: rtl/tt_um_salomon9920_pwm_bank.sv
// Multi-channel PWM bank in the TinyTapeout pin frame: one shared period counter,
// double-buffered duty/period registers that load from their shadows at period wrap.
module tt_um_salomon9920_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int PRESC    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [7:0] PRESC_LAST  = 8'(PRESC - 1);
    localparam logic [2:0] PERIOD_ADDR = 3'd7;

    logic       stb_s1_q, stb_s2_q, stb_s3_q;
    logic       run_s1_q, run_s2_q;
    logic       run_s, run_en, wr, tick, wrap, load_act;
    logic [2:0] addr;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] presc_q, presc_d;
    logic       pending_q, pending_d;
    logic [7:0] period_shadow_q, period_act_q;
    logic [7:0] pwm;
    logic       unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1_q <= 1'b0;
            stb_s2_q <= 1'b0;
            stb_s3_q <= 1'b0;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
        end else begin
            stb_s1_q <= uio_in[3];
            stb_s2_q <= stb_s1_q;
            stb_s3_q <= stb_s2_q;
            run_s1_q <= uio_in[4];
            run_s2_q <= run_s1_q;
        end
    end

    // Address is taken straight from the pins; the writer holds it stable across the sync delay.
    assign addr     = uio_in[2:0];
    assign run_s    = run_s2_q;
    assign run_en   = run_s & ena;
    assign wr       = stb_s2_q & ~stb_s3_q;
    assign tick     = run_en && (presc_q == PRESC_LAST);
    assign wrap     = tick && (cnt_q == period_act_q);
    assign load_act = ~run_s | wrap;

    always_comb begin
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        pending_d = pending_q;
        if (!run_s) begin
            cnt_d   = 8'd0;
            presc_d = 8'd0;
        end else if (ena) begin
            if (tick) begin
                presc_d = 8'd0;
                cnt_d   = wrap ? 8'd0 : cnt_q + 8'd1;
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
        // A write landing on the load cycle must survive it: the new value is still waiting.
        if (wr) begin
            pending_d = 1'b1;
        end else if (load_act) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= 8'd0;
            presc_q         <= 8'd0;
            pending_q       <= 1'b0;
            period_shadow_q <= 8'hFF;
            period_act_q    <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            pending_q <= pending_d;
            if (wr && addr == PERIOD_ADDR) begin
                period_shadow_q <= ui_in;
            end
            if (load_act) begin
                period_act_q <= period_shadow_q;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        if (gi < CHANNELS) begin : g_on
            logic [7:0] duty_shadow_q, duty_act_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_shadow_q <= 8'd0;
                    duty_act_q    <= 8'd0;
                end else begin
                    if (wr && addr == 3'(gi)) begin
                        duty_shadow_q <= ui_in;
                    end
                    if (load_act) begin
                        duty_act_q <= duty_shadow_q;
                    end
                end
            end

            assign pwm[gi] = run_en & (cnt_q < duty_act_q);
        end else begin : g_off
            assign pwm[gi] = 1'b0;
        end
    end

    assign uo_out      = pwm;
    assign uio_out     = {run_en, pending_q, wrap, 5'b00000};
    assign uio_oe      = 8'b1110_0000;
    assign unused_bits = &{1'b0, uio_in[7:5]};

endmodule

// File: tb/tb_tt_um_salomon9920_pwm_bank.sv
// Directed bench for the PWM bank: instance A (PRESC=1) and instance B (PRESC=3).
module tb_tt_um_salomon9920_pwm_bank;

    logic       clk;
    logic       rst_n;
    logic       a_ena, b_ena;
    logic [7:0] a_ui, b_ui;
    logic       a_run, b_run, a_stb, b_stb;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_uio_in, b_uio_in;
    logic [7:0] a_uo, b_uo, a_uio_out, b_uio_out, a_uio_oe, b_uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    assign a_uio_in = {3'b000, a_run, a_stb, a_addr};
    assign b_uio_in = {3'b000, b_run, b_stb, b_addr};

    tt_um_salomon9920_pwm_bank #(.CHANNELS(4), .PRESC(1)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (a_ena),
        .ui_in   (a_ui),
        .uo_out  (a_uo),
        .uio_in  (a_uio_in),
        .uio_out (a_uio_out),
        .uio_oe  (a_uio_oe)
    );

    tt_um_salomon9920_pwm_bank #(.CHANNELS(4), .PRESC(3)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (b_ena),
        .ui_in   (b_ui),
        .uo_out  (b_uo),
        .uio_in  (b_uio_in),
        .uio_out (b_uio_out),
        .uio_oe  (b_uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input bit sel, input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        if (sel) begin
            b_addr = addr; b_ui = data; b_stb = 1'b1;
        end else begin
            a_addr = addr; a_ui = data; a_stb = 1'b1;
        end
        repeat (3) @(negedge clk);
        if (sel) b_stb = 1'b0;
        else     a_stb = 1'b0;
        repeat (3) @(negedge clk);
        $display("write dut=%0d addr=%0d data=0x%02h", sel, addr, data);
    endtask

    // Counts negedges until the wrap pulse is seen; -1 if it never comes.
    task automatic wait_wrap(input bit sel, output int cycles, output logic [7:0] uo_or);
        cycles = -1;
        uo_or  = 8'h00;
        for (int i = 1; i <= 1000 && cycles < 0; i++) begin
            @(negedge clk);
            uo_or = uo_or | (sel ? b_uo : a_uo);
            if (sel ? b_uio_out[5] : a_uio_out[5]) cycles = i;
        end
    endtask

    task automatic test_reset();
        int c1, c2;
        logic [7:0] o1, o2;
        rst_n = 1'b0;
        a_ena = 1'b1; b_ena = 1'b1;
        a_ui = 8'h00; b_ui = 8'h00;
        a_run = 1'b0; b_run = 1'b0; a_stb = 1'b0; b_stb = 1'b0;
        a_addr = 3'd0; b_addr = 3'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_uo !== 8'h00) begin n_err++; $display("FAIL reset_uo got=%h exp=00", a_uo); end
        n_cmp++; if (a_uio_out !== 8'h00) begin n_err++; $display("FAIL reset_uio_out got=%h exp=00", a_uio_out); end
        n_cmp++; if (a_uio_oe !== 8'hE0) begin n_err++; $display("FAIL reset_uio_oe got=%h exp=e0", a_uio_oe); end
        rst_n = 1'b1;

        do_write(1'b0, 3'd0, 8'h80);
        a_run = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (a_uo[0] !== 1'b1) begin n_err++; $display("FAIL prerst_ch0 got=%b exp=1", a_uo[0]); end
        n_cmp++; if (a_uio_out[7] !== 1'b1) begin n_err++; $display("FAIL prerst_running got=%b exp=1", a_uio_out[7]); end

        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_uo !== 8'h00) begin n_err++; $display("FAIL midrst_uo got=%h exp=00", a_uo); end
        n_cmp++; if (a_uio_out !== 8'h00) begin n_err++; $display("FAIL midrst_uio_out got=%h exp=00", a_uio_out); end
        n_cmp++; if (a_uio_oe !== 8'hE0) begin n_err++; $display("FAIL midrst_uio_oe got=%h exp=e0", a_uio_oe); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wait_wrap(1'b0, c1, o1);
        wait_wrap(1'b0, c2, o2);
        n_cmp++; if (c2 !== 256) begin n_err++; $display("FAIL reset_period got=%0d exp=256", c2); end
        n_cmp++; if ((o1 | o2) !== 8'h00) begin n_err++; $display("FAIL reset_duty_low got=%h exp=00", o1 | o2); end
        $display("test_reset done, wrap spacing %0d", c2);
    endtask

    task automatic test_basic();
        int c;
        logic [7:0] o, v0, v1, v2, vw;
        logic [4:0] hi;
        a_run = 1'b0;
        repeat (3) @(negedge clk);
        do_write(1'b0, 3'd7, 8'd3);
        do_write(1'b0, 3'd0, 8'd2);
        do_write(1'b0, 3'd1, 8'd0);
        do_write(1'b0, 3'd2, 8'd4);
        @(negedge clk);
        a_run = 1'b1;
        wait_wrap(1'b0, c, o);
        n_cmp++; if (c !== 5) begin n_err++; $display("FAIL run_latency got=%0d exp=5", c); end
        hi = 5'd0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            v0[k] = a_uo[0]; v1[k] = a_uo[1]; v2[k] = a_uo[2]; vw[k] = a_uio_out[5];
            hi = hi | a_uo[7:3];
        end
        n_cmp++; if (v0 !== 8'b0110_0110) begin n_err++; $display("FAIL basic_ch0 got=%b exp=01100110", v0); end
        n_cmp++; if (v1 !== 8'h00) begin n_err++; $display("FAIL basic_ch1 got=%b exp=00000000", v1); end
        n_cmp++; if (v2 !== 8'hFF) begin n_err++; $display("FAIL basic_ch2 got=%b exp=11111111", v2); end
        n_cmp++; if (vw !== 8'b0001_0001) begin n_err++; $display("FAIL basic_wrap got=%b exp=00010001", vw); end
        n_cmp++; if (hi !== 5'd0) begin n_err++; $display("FAIL basic_upper got=%b exp=00000", hi); end
        $display("test_basic done, ch0=%b wrap=%b", v0, vw);
    endtask

    task automatic test_double_buffer();
        int c;
        logic [7:0] o, v0, vp;
        wait_wrap(1'b0, c, o);
        repeat (3) @(negedge clk);
        a_addr = 3'd0; a_ui = 8'd1; a_stb = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v0[k] = a_uo[0]; vp[k] = a_uio_out[6];
        end
        a_stb = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (v0 !== 8'b0001_0011) begin n_err++; $display("FAIL dbuf_ch0 got=%b exp=00010011", v0); end
        n_cmp++; if (vp !== 8'b0000_1110) begin n_err++; $display("FAIL dbuf_pending got=%b exp=00001110", vp); end
        $display("test_double_buffer done, ch0=%b pending=%b", v0, vp);
    endtask

    task automatic test_collision();
        int c;
        logic [7:0] o, v0, vp;
        wait_wrap(1'b0, c, o);
        repeat (2) @(negedge clk);
        a_addr = 3'd0; a_ui = 8'd3; a_stb = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v0[k] = a_uo[0]; vp[k] = a_uio_out[6];
        end
        a_stb = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (v0 !== 8'b0111_0001) begin n_err++; $display("FAIL collide_ch0 got=%b exp=01110001", v0); end
        n_cmp++; if (vp !== 8'b0000_1111) begin n_err++; $display("FAIL collide_pending got=%b exp=00001111", vp); end
        $display("test_collision done, ch0=%b pending=%b", v0, vp);
    endtask

    task automatic test_strobe_hold_bad_addr();
        int c, rises;
        logic prev, cur;
        logic [7:0] o, v0, v1, v2, vw;
        @(negedge clk);
        a_addr = 3'd1; a_ui = 8'd2; a_stb = 1'b1;
        prev = a_uio_out[6];
        rises = 0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            cur = a_uio_out[6];
            if (cur && !prev) rises++;
            prev = cur;
            if (k == 6) a_ui = 8'd3;
            if (k == 20) a_stb = 1'b0;
        end
        n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL hold_writes got=%0d exp=1", rises); end

        wait_wrap(1'b0, c, o);
        a_addr = 3'd5; a_ui = 8'h01; a_stb = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_uio_out[6] !== 1'b1) begin n_err++; $display("FAIL badaddr_pending got=%b exp=1", a_uio_out[6]); end
        a_stb = 1'b0;
        repeat (3) @(negedge clk);
        wait_wrap(1'b0, c, o);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            v0[k] = a_uo[0]; v1[k] = a_uo[1]; v2[k] = a_uo[2]; vw[k] = a_uio_out[5];
        end
        n_cmp++; if (v0 !== 8'b1110_1110) begin n_err++; $display("FAIL badaddr_ch0 got=%b exp=11101110", v0); end
        n_cmp++; if (v1 !== 8'b0110_0110) begin n_err++; $display("FAIL badaddr_ch1 got=%b exp=01100110", v1); end
        n_cmp++; if (v2 !== 8'hFF) begin n_err++; $display("FAIL badaddr_ch2 got=%b exp=11111111", v2); end
        n_cmp++; if (vw !== 8'b0001_0001) begin n_err++; $display("FAIL badaddr_wrap got=%b exp=00010001", vw); end
        $display("test_strobe_hold_bad_addr done, rises=%0d ch1=%b", rises, v1);
    endtask

    task automatic test_prescaler_ena();
        int c, found;
        logic [7:0] o, uo_or;
        logic run_or, ch0_at7;
        do_write(1'b1, 3'd7, 8'd1);
        do_write(1'b1, 3'd0, 8'd1);
        @(negedge clk);
        b_run = 1'b1;
        wait_wrap(1'b1, c, o);
        wait_wrap(1'b1, c, o);
        n_cmp++; if (c !== 6) begin n_err++; $display("FAIL presc_period got=%0d exp=6", c); end
        found = -1; uo_or = 8'h00; run_or = 1'b0; ch0_at7 = 1'b0;
        for (int i = 1; i <= 40 && found < 0; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= 6) begin
                uo_or  = uo_or | b_uo;
                run_or = run_or | b_uio_out[7];
            end
            if (i == 7) ch0_at7 = b_uo[0];
            if (b_uio_out[5]) found = i;
            if (i == 1) b_ena = 1'b0;
            if (i == 6) b_ena = 1'b1;
        end
        n_cmp++; if (uo_or !== 8'h00) begin n_err++; $display("FAIL ena_low_uo got=%h exp=00", uo_or); end
        n_cmp++; if (run_or !== 1'b0) begin n_err++; $display("FAIL ena_low_running got=%b exp=0", run_or); end
        n_cmp++; if (ch0_at7 !== 1'b1) begin n_err++; $display("FAIL ena_resume_ch0 got=%b exp=1", ch0_at7); end
        n_cmp++; if (found !== 11) begin n_err++; $display("FAIL ena_late_wrap got=%0d exp=11", found); end
        $display("test_prescaler_ena done, late wrap after %0d cycles", found);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_buffer();
        test_collision();
        test_strobe_hold_bad_addr();
        test_prescaler_ena();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
